// File: rtl/lsu_mem_ctrl_if.sv
// Handshake bundles for the load/store unit: EXU-side request plus writeback result,
// and the word-aligned data-memory port.
interface lsu_exu_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_addr;
   logic [31:0] in_wdata;
   logic        in_ren;
   logic        in_wen;
   logic [2:0]  in_funct3;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] load_data;
   logic [1:0]  out_err;

   modport master (
      output in_valid, in_addr, in_wdata, in_ren, in_wen, in_funct3, out_ready,
      input  in_ready, out_valid, load_data, out_err
   );
   modport slave (
      input  in_valid, in_addr, in_wdata, in_ren, in_wen, in_funct3, out_ready,
      output in_ready, out_valid, load_data, out_err
   );
endinterface

interface lsu_mem_if;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_addr;
   logic        mem_wen;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_resp_valid;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
      input  mem_req_ready, mem_resp_valid, mem_rdata
   );
   modport slave (
      input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
      output mem_req_ready, mem_resp_valid, mem_rdata
   );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: one op per handshake, word-aligned memory request with byte mask,
// bounded wait for the response, then load alignment/extension toward writeback.
module lsu_mem_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic      clk,
   input  logic      rst,
   lsu_exu_if.slave  exu,
   lsu_mem_if.master mem
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

   localparam logic [1:0] ERR_OK  = 2'b00;
   localparam logic [1:0] ERR_ILL = 2'b01;
   localparam logic [1:0] ERR_TO  = 2'b10;
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

   function automatic logic [31:0] extract_load(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] rd);
      logic [7:0]  b;
      logic [15:0] h;
      b = rd[{off, 3'b000} +: 8];
      h = rd[{off[1], 4'b0000} +: 16];
      case (f3)
         3'b000:  extract_load = {{24{b[7]}}, b};
         3'b100:  extract_load = {24'b0, b};
         3'b001:  extract_load = {{16{h[15]}}, h};
         3'b101:  extract_load = {16'b0, h};
         default: extract_load = rd;
      endcase
   endfunction

   // Returns {byte mask, lane-shifted store data}.
   function automatic logic [35:0] store_lanes(input logic [2:0]  f3,
                                               input logic [1:0]  off,
                                               input logic [31:0] wd);
      case (f3[1:0])
         2'b00:   store_lanes = {4'b0001 << off, wd << {off, 3'b000}};
         2'b01:   store_lanes = {4'b0011 << off, wd << {off, 3'b000}};
         default: store_lanes = {4'b1111, wd};
      endcase
   endfunction

   state_e      state_q, state_d;
   logic [1:0]  off_q, off_d;
   logic [2:0]  f3_q, f3_d;
   logic        wen_q, wen_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_wmask_q, mem_wmask_d;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] load_data_q, load_data_d;
   logic [1:0]  err_q, err_d;

   logic        is_mem;
   logic        illegal;
   logic [35:0] lanes;

   always_comb begin
      is_mem  = exu.in_ren || exu.in_wen;
      illegal = (exu.in_ren && exu.in_wen)
             || (exu.in_funct3 == 3'b011) || (exu.in_funct3 == 3'b110) || (exu.in_funct3 == 3'b111)
             || (exu.in_wen && exu.in_funct3[2])
             || ((exu.in_funct3[1:0] == 2'b01) && exu.in_addr[0])
             || ((exu.in_funct3[1:0] == 2'b10) && (exu.in_addr[1:0] != 2'b00));
      lanes   = store_lanes(exu.in_funct3, exu.in_addr[1:0], exu.in_wdata);
   end

   always_comb begin
      state_d     = state_q;
      off_d       = off_q;
      f3_d        = f3_q;
      wen_d       = wen_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wmask_d = mem_wmask_q;
      cnt_d       = cnt_q;
      load_data_d = load_data_q;
      err_d       = err_q;
      case (state_q)
         S_IDLE: begin
            if (exu.in_valid) begin
               off_d = exu.in_addr[1:0];
               f3_d  = exu.in_funct3;
               wen_d = exu.in_wen;
               if (!is_mem || illegal) begin
                  state_d     = S_RESP;
                  load_data_d = 32'h0;
                  err_d       = is_mem ? ERR_ILL : ERR_OK;
               end else begin
                  state_d     = S_REQ;
                  mem_addr_d  = {exu.in_addr[31:2], 2'b00};
                  mem_wmask_d = exu.in_wen ? lanes[35:32] : 4'b0000;
                  mem_wdata_d = exu.in_wen ? lanes[31:0] : 32'h0;
               end
            end
         end
         S_REQ: begin
            if (mem.mem_req_ready) begin
               state_d = S_WAIT;
               cnt_d   = 16'h0;
            end
         end
         S_WAIT: begin
            // A response in the final counted cycle still wins over the timeout.
            if (mem.mem_resp_valid) begin
               state_d     = S_RESP;
               err_d       = ERR_OK;
               load_data_d = wen_q ? 32'h0 : extract_load(f3_q, off_q, mem.mem_rdata);
            end else if (cnt_q == CNT_LAST) begin
               state_d     = S_RESP;
               err_d       = ERR_TO;
               load_data_d = 32'h0;
            end else begin
               cnt_d = cnt_q + 16'h1;
            end
         end
         S_RESP: begin
            if (exu.out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         off_q       <= 2'b00;
         f3_q        <= 3'b000;
         wen_q       <= 1'b0;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
         mem_wmask_q <= 4'b0000;
         cnt_q       <= 16'h0;
         load_data_q <= 32'h0;
         err_q       <= ERR_OK;
      end else begin
         state_q     <= state_d;
         off_q       <= off_d;
         f3_q        <= f3_d;
         wen_q       <= wen_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wmask_q <= mem_wmask_d;
         cnt_q       <= cnt_d;
         load_data_q <= load_data_d;
         err_q       <= err_d;
      end
   end

   assign exu.in_ready      = (state_q == S_IDLE);
   assign exu.out_valid     = (state_q == S_RESP);
   assign exu.load_data     = load_data_q;
   assign exu.out_err       = err_q;
   assign mem.mem_req_valid = (state_q == S_REQ);
   assign mem.mem_addr      = mem_addr_q;
   assign mem.mem_wen       = wen_q;
   assign mem.mem_wdata     = mem_wdata_q;
   assign mem.mem_wmask     = mem_wmask_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: loads, stores, illegal ops, stalls, timeout and reset.
module tb_lsu_mem_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   lsu_exu_if exu ();
   lsu_mem_if mem ();

   lsu_mem_ctrl #(.TIMEOUT_CYC(4)) dut (
      .clk (clk),
      .rst (rst),
      .exu (exu),
      .mem (mem)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic ren, input logic wen, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata);
      exu.in_valid  = 1'b1;
      exu.in_ren    = ren;
      exu.in_wen    = wen;
      exu.in_funct3 = f3;
      exu.in_addr   = addr;
      exu.in_wdata  = wdata;
      @(negedge clk);
      exu.in_valid  = 1'b0;
   endtask

   task automatic retire(input string tag);
      exu.out_ready = 1'b1;
      @(negedge clk);
      exu.out_ready = 1'b0;
      check_val({tag, ".ov_drop"}, exu.out_valid, 0);
      check_val({tag, ".in_ready"}, exu.in_ready, 1);
   endtask

   // Full memory transaction with request accepted at once and response after wait_cyc idle WAIT cycles.
   task automatic run_mem(input string tag, input logic ren, input logic wen, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                          input logic [31:0] exp_addr, input logic [3:0] exp_mask,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_load, input int wait_cyc);
      check_val({tag, ".rdy"}, exu.in_ready, 1);
      issue(ren, wen, f3, addr, wdata);
      check_val({tag, ".req"}, mem.mem_req_valid, 1);
      check_val({tag, ".addr"}, mem.mem_addr, exp_addr);
      check_val({tag, ".wen"}, mem.mem_wen, wen);
      check_val({tag, ".mask"}, mem.mem_wmask, exp_mask);
      if (wen) check_val({tag, ".wdata"}, mem.mem_wdata, exp_wdata);
      mem.mem_req_ready = 1'b1;
      @(negedge clk);
      mem.mem_req_ready = 1'b0;
      check_val({tag, ".req_drop"}, mem.mem_req_valid, 0);
      for (int i = 0; i < wait_cyc; i++) begin
         check_val({tag, ".noack"}, exu.out_valid, 0);
         @(negedge clk);
      end
      check_val({tag, ".ov_early"}, exu.out_valid, 0);
      mem.mem_resp_valid = 1'b1;
      mem.mem_rdata      = rdata;
      @(negedge clk);
      mem.mem_resp_valid = 1'b0;
      check_val({tag, ".ov"}, exu.out_valid, 1);
      check_val({tag, ".load"}, exu.load_data, exp_load);
      check_val({tag, ".err"}, exu.out_err, 2'b00);
      retire(tag);
   endtask

   // Ops that finish without touching memory (non-mem and illegal).
   task automatic run_direct(input string tag, input logic ren, input logic wen, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [1:0] exp_err);
      check_val({tag, ".rdy"}, exu.in_ready, 1);
      issue(ren, wen, f3, addr, 32'hFFFF_FFFF);
      check_val({tag, ".noreq"}, mem.mem_req_valid, 0);
      check_val({tag, ".ov"}, exu.out_valid, 1);
      check_val({tag, ".busy"}, exu.in_ready, 0);
      check_val({tag, ".err"}, exu.out_err, exp_err);
      check_val({tag, ".load"}, exu.load_data, 0);
      retire(tag);
   endtask

   initial begin
      exu.in_valid       = 1'b0;
      exu.in_ren         = 1'b0;
      exu.in_wen         = 1'b0;
      exu.in_funct3      = 3'b000;
      exu.in_addr        = 32'h0;
      exu.in_wdata       = 32'h0;
      exu.out_ready      = 1'b0;
      mem.mem_req_ready  = 1'b0;
      mem.mem_resp_valid = 1'b0;
      mem.mem_rdata      = 32'h0;

      repeat (2) @(negedge clk);
      check_val("rst.in_ready", exu.in_ready, 1);
      check_val("rst.req", mem.mem_req_valid, 0);
      check_val("rst.ov", exu.out_valid, 0);
      check_val("rst.load", exu.load_data, 0);
      check_val("rst.err", exu.out_err, 0);
      check_val("rst.addr", mem.mem_addr, 0);
      check_val("rst.mask", mem.mem_wmask, 0);
      rst = 1'b0;
      @(negedge clk);

      run_mem("lw",    1, 0, 3'b010, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 32'h8000_0004, 4'b0000, 32'h0, 32'hDEAD_BEEF, 0);
      run_mem("lb3",   1, 0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_1234, 32'h8000_0000, 4'b0000, 32'h0, 32'hFFFF_FF80, 0);
      run_mem("lbu3",  1, 0, 3'b100, 32'h8000_0003, 32'h0, 32'h80FF_1234, 32'h8000_0000, 4'b0000, 32'h0, 32'h0000_0080, 0);
      run_mem("lh2",   1, 0, 3'b001, 32'h8000_0002, 32'h0, 32'h80FF_1234, 32'h8000_0000, 4'b0000, 32'h0, 32'hFFFF_80FF, 0);
      run_mem("lhu0",  1, 0, 3'b101, 32'h8000_0000, 32'h0, 32'h80FF_9234, 32'h8000_0000, 4'b0000, 32'h0, 32'h0000_9234, 0);
      run_mem("lb1",   1, 0, 3'b000, 32'h0000_0021, 32'h0, 32'h80FF_1234, 32'h0000_0020, 4'b0000, 32'h0, 32'h0000_0012, 0);
      run_mem("sb3",   0, 1, 3'b000, 32'h0000_0013, 32'h0000_00AB, 32'hFFFF_FFFF, 32'h0000_0010, 4'b1000, 32'hAB00_0000, 32'h0, 2);
      run_mem("sb0",   0, 1, 3'b000, 32'h0000_0010, 32'h0000_00AB, 32'hFFFF_FFFF, 32'h0000_0010, 4'b0001, 32'h0000_00AB, 32'h0, 1);
      run_mem("sh2",   0, 1, 3'b001, 32'h0000_0012, 32'h0000_BEEF, 32'hFFFF_FFFF, 32'h0000_0010, 4'b1100, 32'hBEEF_0000, 32'h0, 0);

      run_direct("lh_odd",  1, 0, 3'b001, 32'h0000_1001, 2'b01);
      run_direct("lw_mis",  1, 0, 3'b010, 32'h0000_1002, 2'b01);
      run_direct("s_f3u",   0, 1, 3'b100, 32'h0000_1000, 2'b01);
      run_direct("f3_011",  1, 0, 3'b011, 32'h0000_1000, 2'b01);
      run_direct("rw_both", 1, 1, 3'b010, 32'h0000_1000, 2'b01);
      run_direct("nonmem",  0, 0, 3'b010, 32'h0000_1003, 2'b00);

      // Request back-pressure with a stray response pulse that must be ignored.
      issue(0, 1, 3'b001, 32'h0000_0202, 32'h5555_A5A5);
      for (int i = 0; i < 5; i++) begin
         mem.mem_resp_valid = (i == 2);
         check_val("stall.req", mem.mem_req_valid, 1);
         check_val("stall.addr", mem.mem_addr, 32'h0000_0200);
         check_val("stall.mask", mem.mem_wmask, 4'b1100);
         check_val("stall.wdata", mem.mem_wdata, 32'hA5A5_0000);
         @(negedge clk);
      end
      mem.mem_resp_valid = 1'b0;
      check_val("stall.still", mem.mem_req_valid, 1);
      check_val("stall.ov", exu.out_valid, 0);
      mem.mem_req_ready = 1'b1;
      @(negedge clk);
      mem.mem_req_ready  = 1'b0;
      mem.mem_resp_valid = 1'b1;
      @(negedge clk);
      mem.mem_resp_valid = 1'b0;
      check_val("stall.ov_ack", exu.out_valid, 1);
      retire("stall");

      // Timeout: four WAIT cycles without response, then a held result ignoring late responses.
      issue(1, 0, 3'b010, 32'h0000_0300, 32'h0);
      mem.mem_req_ready = 1'b1;
      @(negedge clk);
      mem.mem_req_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check_val("to.wait", exu.out_valid, 0);
         @(negedge clk);
      end
      check_val("to.ov", exu.out_valid, 1);
      check_val("to.err", exu.out_err, 2'b10);
      check_val("to.load", exu.load_data, 0);
      for (int i = 0; i < 3; i++) begin
         mem.mem_resp_valid = (i == 0);
         mem.mem_rdata      = 32'h1357_9BDF;
         @(negedge clk);
         check_val("hold.ov", exu.out_valid, 1);
         check_val("hold.err", exu.out_err, 2'b10);
         check_val("hold.load", exu.load_data, 0);
      end
      mem.mem_resp_valid = 1'b0;
      retire("to");

      // Leave nonzero result and memory-port state, then reset during WAIT.
      run_mem("lw2", 1, 0, 3'b010, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 32'h0000_0040, 4'b0000, 32'h0, 32'hCAFE_F00D, 0);
      issue(0, 1, 3'b010, 32'h0000_0014, 32'h1234_5678);
      check_val("sw.mask", mem.mem_wmask, 4'b1111);
      check_val("sw.wdata", mem.mem_wdata, 32'h1234_5678);
      mem.mem_req_ready = 1'b1;
      @(negedge clk);
      mem.mem_req_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_val("wrst.in_ready", exu.in_ready, 1);
      check_val("wrst.req", mem.mem_req_valid, 0);
      check_val("wrst.ov", exu.out_valid, 0);
      check_val("wrst.load", exu.load_data, 0);
      check_val("wrst.err", exu.out_err, 0);
      check_val("wrst.addr", mem.mem_addr, 0);
      check_val("wrst.wdata", mem.mem_wdata, 0);
      check_val("wrst.mask", mem.mem_wmask, 0);
      mem.mem_resp_valid = 1'b1;
      @(negedge clk);
      mem.mem_resp_valid = 1'b0;
      @(negedge clk);
      check_val("late.ov", exu.out_valid, 0);
      check_val("late.in_ready", exu.in_ready, 1);
      check_val("late.load", exu.load_data, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
